// File: rtl/ov7670_vga_reader.sv
// Display-side reader for the 1-bit OV7670 frame buffer: 640x480@60 VGA timing, raster read, mono RGB.
// Optional 1-pixel white frame border when OV7670_VGA_BORDER_EN is defined.
module ov7670_vga_reader #(
   parameter int ADDR_W   = 19,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Enable,
   output logic [ADDR_W-1:0] ReadAddr,
   input  logic              RamData,
   output logic              HSync,
   output logic              VSync,
   output logic [3:0]        VgaR,
   output logic [3:0]        VgaG,
   output logic [3:0]        VgaB,
   output logic              FrameStart
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);

   localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
   localparam logic [H_W-1:0] H_SYNC_ON  = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] H_SYNC_OFF = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
   localparam logic [V_W-1:0] V_SYNC_ON  = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] V_SYNC_OFF = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef OV7670_VGA_BORDER_EN
   localparam logic [H_W-1:0] H_ACT_LAST = H_W'(H_ACTIVE - 1);
   localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);
`endif

   logic [H_W-1:0] h_count;
   logic [H_W-1:0] h_next;
   logic [V_W-1:0] v_count;
   logic [V_W-1:0] v_next;
   logic           cur_active;
   logic           next_active;
   logic           next_origin;
   logic           hsync_area;
   logic           vsync_area;
   logic           pixel;

   always_comb begin
      h_next = h_count + 1'b1;
      v_next = v_count;
      if (h_count == H_LAST) begin
         h_next = '0;
         v_next = (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end
      next_active = (h_next < H_ACT) && (v_next < V_ACT);
      next_origin = (h_next == '0) && (v_next == '0);
      cur_active  = (h_count < H_ACT) && (v_count < V_ACT);
      hsync_area  = (h_count >= H_SYNC_ON) && (h_count <= H_SYNC_OFF);
      vsync_area  = (v_count >= V_SYNC_ON) && (v_count <= V_SYNC_OFF);
      pixel       = RamData;
`ifdef OV7670_VGA_BORDER_EN
      if ((h_count == '0) || (h_count == H_ACT_LAST) ||
          (v_count == '0) || (v_count == V_ACT_LAST)) begin
         pixel = 1'b1;
      end
`endif
   end

   // RamData already reflects ReadAddr of the current position, so outputs
   // registered here describe the position being left: one tick of lag.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         h_count    <= '0;
         v_count    <= '0;
         ReadAddr   <= '0;
         HSync      <= 1'b1;
         VSync      <= 1'b1;
         VgaR       <= 4'h0;
         VgaG       <= 4'h0;
         VgaB       <= 4'h0;
         FrameStart <= 1'b0;
      end else begin
         FrameStart <= 1'b0;
         if (Enable) begin
            h_count <= h_next;
            v_count <= v_next;
            if (next_origin) begin
               ReadAddr <= '0;
            end else if (next_active) begin
               ReadAddr <= ReadAddr + 1'b1;
            end
            HSync      <= ~hsync_area;
            VSync      <= ~vsync_area;
            VgaR       <= cur_active ? {4{pixel}} : 4'h0;
            VgaG       <= cur_active ? {4{pixel}} : 4'h0;
            VgaB       <= cur_active ? {4{pixel}} : 4'h0;
            FrameStart <= next_origin;
         end
      end
   end

endmodule
